frame_receiver: RTL and testbench
=================================

Name: frame_receiver

Overview:
- Serial front-end that sits directly upstream of the four-digit display latch stage.
- Receives framed serial words on a single line, checks each frame and decodes a 2-bit channel address into one-hot select lines.
- Presents the 8-bit payload together with a held receive strobe (priem) that the display stage's delay taps turn into a single write pulse.
- Bad frames are flagged on err and never reach the display stage.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- PRIEM_HOLD, 4, cycles priem stays high per good frame; >= 4, because the display stage taps priem at delays 2 and 3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- inp  output  8  received payload; held until the next good frame.
- priem  output  1  receive strobe, high PRIEM_HOLD cycles per good frame.
- SET1..SET4  output  1 each  one-hot decode of the frame address (00->SET1 .. 11->SET4); held with inp.
- err  output  1  one-cycle pulse on a parity or stop-bit error.
- busy  output  1  high while a frame is in progress (START..STOP states).

Behaviour:
- Reset (rst=0, asynchronous):
  - inp=0, priem=0, SET1..SET4=0, err=0, busy=0.
  - FSM goes to IDLE; all counters are cleared.
- Synchroniser: rx passes through 2 flops; rx_s is the synchronised value. All logic uses rx_s only.
- Frame format, 13 bits, LSB first:
  - start=0
  - addr[0], addr[1]
  - data[0..7]
  - parity: even over addr+data, so the total count of 1s in addr, data and parity is even
  - stop=1
- Bit timing:
  - T0 is the first cycle with rx_s=0 while in IDLE.
  - Bit k (k=0..12) is sampled at cycle T0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
- FSM states:
  - IDLE: on rx_s=0, go to START; the bit counter loads CLKS_PER_BIT/2.
  - START: at the sample point, rx_s=1 is a glitch; return to IDLE with no err. rx_s=0 goes to ADDR.
  - ADDR (2 samples) -> DATA (8 samples) -> PARITY (1 sample) -> STOP (1 sample).
  - STOP sample, all three cases return to IDLE in the next cycle:
    - rx_s=1 and parity OK: commit the frame.
    - rx_s=0: framing error.
    - parity bad: parity error.
- Commit (cycle after the STOP sample):
  - inp <= data.
  - SETn <= decode(addr); exactly one SET is high.
  - priem rises in the same cycle and stays high for exactly PRIEM_HOLD cycles.
- Error (cycle after the STOP sample): err=1 for 1 cycle. inp, SET and priem are unchanged.
- data=0x00 is a legal frame and is committed normally; the display stage ignores zero.
- priem hold counter:
  - A new frame starting during the hold does not shorten or extend the hold.
  - A frame lasts >= 13*CLKS_PER_BIT cycles, far longer than PRIEM_HOLD, so holds cannot overlap.
- inp and SET change only on commit, so they are stable throughout every priem high period.
- Reset mid-frame: outputs return to reset values immediately. The partial frame is discarded.
- After reset release the receiver waits in IDLE. A line held low at release starts a frame at the first cycle it is low.
- busy=1 from the cycle START is entered through the STOP sample.

Test Plan (CLKS_PER_BIT=16, PRIEM_HOLD=4):
- Good frame, addr=2'b10, data=0xA5, parity=1, stop=1:
  - inp=0xA5, SET3=1 (others 0) in the cycle after the STOP sample.
  - priem high exactly 4 cycles; err stays 0.
- Back-to-back frames addr=0/data=0x3C then addr=3/data=0x01:
  - first: SET1, inp=0x3C, priem high 4 cycles.
  - second: inp=0x01, SET4 only, a second 4-cycle priem.
  - inp is stable during each priem window.
- Same frame as the first scenario with the parity bit flipped to 0: err pulses 1 cycle; inp, SET1..SET4 and priem keep their prior values.
- Stop bit driven 0: err pulses 1 cycle, no commit. A following valid frame (addr=1, data=0x7E) commits SET2, inp=0x7E.
- rx low for 5 cycles then high (start-bit glitch): FSM returns to IDLE, busy drops, no err, no priem.
- rst asserted in the middle of the DATA bits:
  - all outputs go to 0 immediately.
  - after release, a clean frame addr=0/data=0x00 commits inp=0x00, SET1=1, priem high 4 cycles.

Source files
------------

// File: rtl/frame_receiver.sv
// frame_receiver: serial front-end for the four-digit display latch stage.
// Receives 13-bit LSB-first frames (start, 2 address bits, 8 data bits,
// even parity, stop), then presents the payload on inp with a one-hot
// channel select and a held receive strobe (priem). Bad frames pulse err
// and leave the presented outputs untouched.
module frame_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PRIEM_HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] inp,
  output logic       priem,
  output logic       SET1,
  output logic       SET2,
  output logic       SET3,
  output logic       SET4,
  output logic       err,
  output logic       busy
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int HOLD_W = $clog2(PRIEM_HOLD + 1);

  // Bit-period counter reloads; a sample is taken when the counter hits 0.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_M1 = HOLD_W'(PRIEM_HOLD - 1);

  // Address and data together occupy ten sample slots.
  localparam logic [3:0] LAST_ADDR = 4'd1;
  localparam logic [3:0] LAST_DATA = 4'd9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  // One-hot decode of the channel address: 00 -> SET1 .. 11 -> SET4.
  function automatic logic [3:0] decode_addr(input logic [1:0] addr);
    logic [3:0] sel;
    sel = 4'b0000;
    sel[addr] = 1'b1;
    return sel;
  endfunction

  logic             rx_meta_q;
  logic             rx_s_q;

  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       shift_q,   shift_d;
  logic             par_q,     par_d;

  logic             commit;
  logic             fail;
  logic             tick;

  logic [7:0]       inp_q;
  logic [3:0]       sel_q;
  logic             priem_q;
  logic [HOLD_W-1:0] hold_q;
  logic             err_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == '0);

  // Frame FSM next-state: mid-bit sampling, shift in addr/data, track parity.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    commit    = 1'b0;
    fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          cnt_d     = HALF_M1;
          bit_idx_d = '0;
          par_d     = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (rx_s_q) begin
            // Line went back high before mid start bit: treat as noise.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_ADDR;
            cnt_d   = FULL_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_ADDR, S_DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[9:1]};
          par_d     = par_q ^ rx_s_q;
          cnt_d     = FULL_M1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (state_q == S_ADDR && bit_idx_q == LAST_ADDR) begin
            state_d = S_DATA;
          end else if (state_q == S_DATA && bit_idx_q == LAST_DATA) begin
            state_d = S_PARITY;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (tick) begin
          par_d   = par_q ^ rx_s_q;
          cnt_d   = FULL_M1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (tick) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          bit_idx_d = '0;
          // Good frame needs a high stop bit and an even count of ones.
          if (rx_s_q && !par_q) begin
            commit = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Frame FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  // Presented payload and select: loaded only on a committed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inp_q <= '0;
      sel_q <= '0;
    end else if (commit) begin
      inp_q <= shift_q[9:2];
      sel_q <= decode_addr(shift_q[1:0]);
    end
  end

  // Receive strobe: rises with the commit and holds for PRIEM_HOLD cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      priem_q <= 1'b0;
      hold_q  <= '0;
    end else if (commit) begin
      priem_q <= 1'b1;
      hold_q  <= HOLD_M1;
    end else if (priem_q) begin
      if (hold_q == '0) begin
        priem_q <= 1'b0;
      end else begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  // Error flag: single-cycle pulse for parity or framing failure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fail;
    end
  end

  assign inp   = inp_q;
  assign priem = priem_q;
  assign SET1  = sel_q[0];
  assign SET2  = sel_q[1];
  assign SET3  = sel_q[2];
  assign SET4  = sel_q[3];
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver with CLKS_PER_BIT=16, PRIEM_HOLD=4.
module tb_frame_receiver;

  localparam int CPB  = 16;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] inp;
  logic       priem;
  logic       SET1, SET2, SET3, SET4;
  logic       err;
  logic       busy;

  frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .PRIEM_HOLD  (HOLD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .inp  (inp),
    .priem(priem),
    .SET1 (SET1),
    .SET2 (SET2),
    .SET3 (SET3),
    .SET4 (SET4),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [3:0] set_v;
  assign set_v = {SET4, SET3, SET2, SET1};

  // Output monitor, sampled on the falling edge.
  int         priem_cycles = 0;
  int         priem_rises  = 0;
  int         err_cycles   = 0;
  int         err_rises    = 0;
  int         unstable     = 0;
  logic [7:0] rise_inp     = 8'h00;
  logic [3:0] rise_set     = 4'h0;
  logic       priem_prev   = 1'b0;
  logic       err_prev     = 1'b0;

  always @(negedge clk) begin
    if (priem) begin
      priem_cycles = priem_cycles + 1;
      if (!priem_prev) begin
        priem_rises = priem_rises + 1;
        rise_inp    = inp;
        rise_set    = set_v;
      end else if (inp !== rise_inp || set_v !== rise_set) begin
        unstable = unstable + 1;
      end
    end
    if (err) begin
      err_cycles = err_cycles + 1;
      if (!err_prev) err_rises = err_rises + 1;
    end
    priem_prev = priem;
    err_prev   = err;
  end

  int total = 0;
  int bad   = 0;

  int b_pc, b_pr, b_ec, b_er, b_un;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic snap();
    b_pc = priem_cycles;
    b_pr = priem_rises;
    b_ec = err_cycles;
    b_er = err_rises;
    b_un = unstable;
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame; bit 0 is the start bit.
  task automatic send_frame(input logic [1:0] a, input logic [7:0] d,
                            input logic flip_par, input logic stop, input int nbits);
    logic [12:0] bits;
    bits[0]    = 1'b0;
    bits[2:1]  = a;
    bits[10:3] = d;
    bits[11]   = (^{a, d}) ^ flip_par;
    bits[12]   = stop;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic expect_commit(input string tag, input logic [1:0] a, input logic [7:0] d);
    logic [3:0] want_set;
    want_set = 4'b0001 << a;
    chk({tag, "_priem_len"},   32'(priem_cycles - b_pc), 32'(HOLD));
    chk({tag, "_priem_rises"}, 32'(priem_rises - b_pr), 32'd1);
    chk({tag, "_no_err"},      32'(err_cycles - b_ec), 32'd0);
    chk({tag, "_inp"},         32'(inp), 32'(d));
    chk({tag, "_set"},         32'(set_v), 32'(want_set));
    chk({tag, "_inp_at_rise"}, 32'(rise_inp), 32'(d));
    chk({tag, "_set_at_rise"}, 32'(rise_set), 32'(want_set));
    chk({tag, "_stable"},      32'(unstable - b_un), 32'd0);
    chk({tag, "_busy"},        32'(busy), 32'd0);
  endtask

  task automatic expect_error(input string tag, input logic [7:0] keep_inp, input logic [3:0] keep_set);
    chk({tag, "_err_len"},   32'(err_cycles - b_ec), 32'd1);
    chk({tag, "_err_rises"}, 32'(err_rises - b_er), 32'd1);
    chk({tag, "_no_priem"},  32'(priem_cycles - b_pc), 32'd0);
    chk({tag, "_inp_kept"},  32'(inp), 32'(keep_inp));
    chk({tag, "_set_kept"},  32'(set_v), 32'(keep_set));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_inp",   32'(inp), 32'h00);
    chk("rst_set",   32'(set_v), 32'h0);
    chk("rst_priem", 32'(priem), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    rst = 1'b1;
    idle_cycles(10);
    chk("idle_busy", 32'(busy), 32'h0);

    // Good frame: addr=2, data=0xA5.
    snap();
    send_frame(2'b10, 8'hA5, 1'b0, 1'b1, 13);
    idle_cycles(2 * CPB);
    expect_commit("f1", 2'b10, 8'hA5);

    // Back-to-back frames.
    snap();
    send_frame(2'b00, 8'h3C, 1'b0, 1'b1, 13);
    expect_commit("b2b1", 2'b00, 8'h3C);
    snap();
    send_frame(2'b11, 8'h01, 1'b0, 1'b1, 13);
    idle_cycles(2 * CPB);
    expect_commit("b2b2", 2'b11, 8'h01);

    // Parity error: outputs keep addr=3/data=0x01.
    snap();
    send_frame(2'b10, 8'hA5, 1'b1, 1'b1, 13);
    idle_cycles(2 * CPB);
    expect_error("par", 8'h01, 4'b1000);

    // Stop-bit error followed by a valid frame.
    snap();
    send_frame(2'b10, 8'h55, 1'b0, 1'b0, 13);
    idle_cycles(3 * CPB);
    expect_error("stop", 8'h01, 4'b1000);
    snap();
    send_frame(2'b01, 8'h7E, 1'b0, 1'b1, 13);
    idle_cycles(2 * CPB);
    expect_commit("after_stop", 2'b01, 8'h7E);

    // Start-bit glitch: 5 cycles low.
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    @(negedge clk);
    idle_cycles(2 * CPB);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_no_err",   32'(err_cycles - b_ec), 32'd0);
    chk("glitch_no_priem", 32'(priem_cycles - b_pc), 32'd0);
    chk("glitch_inp_kept", 32'(inp), 32'h7E);

    // Reset in the middle of the data bits.
    send_frame(2'b11, 8'hFF, 1'b0, 1'b1, 5);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("mid_busy_hi", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_inp",   32'(inp), 32'h00);
    chk("mid_rst_set",   32'(set_v), 32'h0);
    chk("mid_rst_priem", 32'(priem), 32'h0);
    chk("mid_rst_err",   32'(err), 32'h0);
    chk("mid_rst_busy",  32'(busy), 32'h0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_cycles(2 * CPB);
    chk("post_rst_busy", 32'(busy), 32'h0);
    snap();
    send_frame(2'b00, 8'h00, 1'b0, 1'b1, 13);
    idle_cycles(2 * CPB);
    expect_commit("zero", 2'b00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
